buffered_router: RTL
====================

BUFFERED_ROUTER -- requirements
Module: buffered_router

Interface
- REQ-001 The block SHALL have parameter N_PORTS, default 4, giving the number of input ports and output ports; legal values are 2, 4 and 8.
- REQ-002 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits.
- REQ-003 The block SHALL define a derived localparam SEL_W = log2(N_PORTS).
- REQ-004 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
- REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 The block SHALL have port in_valid, input, N_PORTS bits: per-input request.
- REQ-007 The block SHALL have port in_dest, input, N_PORTS*SEL_W bits: destination output index, with slice i belonging to input i.
- REQ-008 The block SHALL have port in_data, input, N_PORTS*DATA_W bits: payload, with slice i belonging to input i.
- REQ-009 The block SHALL have port in_ready, output, N_PORTS bits: per-input accept.
- REQ-010 The block SHALL have port out_valid, output, N_PORTS bits: per-output data present.
- REQ-011 The block SHALL have port out_data, output, N_PORTS*DATA_W bits: registered payload per output.
- REQ-012 The block SHALL have port out_src, output, N_PORTS*SEL_W bits: index of the input that supplied out_data.
- REQ-013 The block SHALL have port out_ready, input, N_PORTS bits: downstream accept per output.

Function
- REQ-014 Each output o SHALL own one holding register containing {valid, data, src}.
- REQ-015 Output o SHALL be "free" in a cycle when out_valid[o]=0, or when out_valid[o]=1 and out_ready[o]=1 (drain and refill in the same cycle).
- REQ-016 Input i SHALL request output o when in_valid[i]=1 and in_dest[i]=o.
- REQ-017 Each output SHALL hold a round-robin pointer rr[o] of SEL_W bits.
- REQ-018 The arbiter SHALL grant the first requesting input found scanning rr[o], rr[o]+1, ... modulo N_PORTS.
- REQ-019 A grant SHALL be issued only when output o is free.
- REQ-020 in_ready[i] SHALL be combinational and equal 1 exactly when input i holds the grant of output in_dest[i].
- REQ-021 in_ready[i] SHALL be 0 whenever in_valid[i]=0.
- REQ-022 A transfer SHALL occur on a rising edge where in_valid[i]=1 and in_ready[i]=1.
- REQ-023 On a transfer from input i to output o, the output register SHALL load data=in_data[i], src=i and valid=1.
- REQ-024 Latency SHALL be exactly one cycle: data accepted at edge k is visible on out_* after edge k.
- REQ-025 After a grant to input g, rr[o] SHALL become (g+1) mod N_PORTS; rr[o] SHALL be unchanged when no grant is made.
- REQ-026 When output o is drained (out_valid[o]=1, out_ready[o]=1) with no new grant, out_valid[o] SHALL clear to 0.
- REQ-027 While out_valid[o]=1 and out_ready[o]=0, out_data[o] and out_src[o] SHALL hold stable.
- REQ-028 Inputs targeting different outputs SHALL transfer in the same cycle independently, giving up to N_PORTS transfers per cycle.
- REQ-029 An input that is not granted SHALL be stalled with in_ready=0 and no data lost; the source is required to hold in_valid, in_dest and in_data stable until its transfer.
- REQ-030 Under continuous contention with out_ready=1, each of the k requesters of an output SHALL be granted once in every k consecutive cycles.
- REQ-031 The output registers SHALL update their data and src fields only on a transfer.
- REQ-032 out_valid and in_ready SHALL contain no X when the inputs are known.

Reset
- REQ-033 While rst_n=0, out_valid SHALL be all zero, out_data SHALL be all zero and out_src SHALL be all zero, asynchronously.
- REQ-034 While rst_n=0, every rr[o] SHALL be 0 and in_ready SHALL be all zero.
- REQ-035 Reset asserted mid-operation SHALL discard buffered data, with no output presented after release.
- REQ-036 The first grant after reset release SHALL occur on the first clk rising edge with rst_n=1.

Verification (N_PORTS=4, DATA_W=8)
- REQ-037 The bench SHALL cover single path: in_valid=0001, in_dest[0]=2, in_data[0]=8'hA5, out_ready=1111 -> in_ready=0001; after one edge out_valid=0100, out_data[2]=A5, out_src[2]=0; next edge out_valid=0000.
- REQ-038 The bench SHALL cover parallel paths: inputs 0..3 to outputs 3,2,1,0 with data 10,11,12,13 -> in_ready=1111; after one edge out_data[3..0]=10,11,12,13 and out_src[3..0]=0,1,2,3.
- REQ-039 The bench SHALL cover round-robin: all inputs to output 1, data=i, out_ready=1111 held for 8 cycles -> out_src[1] sequence 0,1,2,3,0,1,2,3 with exactly one in_ready high per cycle.
- REQ-040 The bench SHALL cover backpressure: output 0 full with 8'h55, out_ready[0]=0, input 2 requesting output 0 with 8'h77 -> in_ready[2]=0 and out_data[0]=55 held; raise out_ready[0] -> in_ready[2]=1 that cycle, and out_data[0]=77 after the edge.
- REQ-041 The bench SHALL cover reset mid-operation: rst_n driven low between clock edges while out_valid=1111 -> out_valid=0000 and out_data=0 immediately; after release, all inputs requesting output 0 -> first grant is to input 0.

Source files
------------

// File: rtl/buffered_router.sv
// N-port buffered crossbar: one {valid, data, src} holding register per output,
// fed by a per-output round-robin arbiter with single-cycle input-to-output latency.
module buffered_router #(
  parameter int N_PORTS = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        in_valid,
  input  logic [N_PORTS*SEL_W-1:0]  in_dest,
  input  logic [N_PORTS*DATA_W-1:0] in_data,
  output logic [N_PORTS-1:0]        in_ready,
  output logic [N_PORTS-1:0]        out_valid,
  output logic [N_PORTS*DATA_W-1:0] out_data,
  output logic [N_PORTS*SEL_W-1:0]  out_src,
  input  logic [N_PORTS-1:0]        out_ready
);

  // Handshake: a beat moves on a rising edge where valid and ready are both 1;
  // in_ready is combinational (grant), out_valid/out_data/out_src are registered.

  logic [SEL_W-1:0]  dest_a  [N_PORTS];
  logic [DATA_W-1:0] data_a  [N_PORTS];
  logic [DATA_W-1:0] data_q  [N_PORTS];
  logic [SEL_W-1:0]  src_q   [N_PORTS];
  logic [SEL_W-1:0]  rr      [N_PORTS];
  logic [SEL_W-1:0]  gnt_idx [N_PORTS];
  logic [N_PORTS-1:0] valid_q;
  logic [N_PORTS-1:0] free;
  logic [N_PORTS-1:0] gnt_any;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    assign dest_a[g] = in_dest[g*SEL_W +: SEL_W];
    assign data_a[g] = in_data[g*DATA_W +: DATA_W];
    assign out_data[g*DATA_W +: DATA_W] = data_q[g];
    assign out_src[g*SEL_W +: SEL_W]    = src_q[g];
  end

  assign out_valid = valid_q;

  // Per-output scan starting at rr[o]; a full register that is draining this
  // cycle counts as free so the output can sustain one beat per cycle.
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      free[o]    = !valid_q[o] || out_ready[o];
      gnt_any[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int k = 0; k < N_PORTS; k++) begin
        cand = rr[o] + SEL_W'(k);
        if (free[o] && !gnt_any[o] && in_valid[cand] && dest_a[cand] == SEL_W'(o)) begin
          gnt_any[o] = 1'b1;
          gnt_idx[o] = cand;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      in_ready[i] = 1'b0;
      for (int o = 0; o < N_PORTS; o++) begin
        if (gnt_any[o] && gnt_idx[o] == SEL_W'(i)) in_ready[i] = rst_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int o = 0; o < N_PORTS; o++) begin
        data_q[o] <= '0;
        src_q[o]  <= '0;
        rr[o]     <= '0;
      end
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (gnt_any[o]) begin
          valid_q[o] <= 1'b1;
          data_q[o]  <= data_a[gnt_idx[o]];
          src_q[o]   <= gnt_idx[o];
          rr[o]      <= gnt_idx[o] + SEL_W'(1);
        end else if (out_ready[o]) begin
          valid_q[o] <= 1'b0;
        end
      end
    end
  end

endmodule
